// File: rtl/rnn_sequencer.sv
// rnn_sequencer: streams character embeddings into the RNN accelerator, steps it,
// triggers the dense layer after the last character and returns its Q8.8 result.
`default_nettype none

module rnn_sequencer #(
  parameter int CHAR_BITS = 6,
  parameter int EMB_BITS  = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          emb_write,
  input  logic [CHAR_BITS+EMB_BITS-1:0] emb_addr,
  input  logic [15:0]                   emb_data,
  input  logic                          char_valid,
  output logic                          char_ready,
  input  logic [CHAR_BITS-1:0]          char_data,
  input  logic                          char_last,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [15:0]                   res_data,
  output logic                          m_read,
  output logic                          m_write,
  output logic [2:0]                    m_addr,
  output logic [31:0]                   m_writedata,
  input  logic [31:0]                   m_readdata,
  output logic                          busy,
  output logic                          err
);

  localparam int AW = CHAR_BITS + EMB_BITS;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WRITE_EMB, S_START, S_POLL_LOAD,
    S_DENSE, S_POLL_VALID, S_READ_RES, S_OUT
  } state_t;

  logic [15:0] table_mem [2**AW];

  state_t                 state_q, state_d;
  logic [CHAR_BITS-1:0]   char_q, char_d;
  logic                   last_q, last_d;
  logic [EMB_BITS-1:0]    k_q, k_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [15:0]            res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;
  logic                   char_ready_q, char_ready_d;
  logic                   busy_q, busy_d;
  logic                   m_read_q, m_read_d;
  logic                   m_write_q, m_write_d;
  logic [2:0]             m_addr_q, m_addr_d;
  logic [31:0]            m_wdata_q, m_wdata_d;
  logic                   unused_rd;

  assign unused_rd = ^m_readdata[31:16];

  always_ff @(posedge clk) begin
    if (emb_write) table_mem[emb_addr] <= emb_data;
  end

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    last_d     = last_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    res_data_d = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (char_valid && char_ready_q) begin
          char_d  = char_data;
          last_d  = char_last;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        k_d     = '0;
        state_d = S_WRITE_EMB;
      end
      S_WRITE_EMB: begin
        if (&k_q) state_d = S_START;
        else      k_d     = k_q + 1'b1;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_POLL_LOAD;
      end
      S_POLL_LOAD: begin
        if (m_readdata[0]) begin
          state_d = last_q ? S_DENSE : S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DENSE: begin
        cnt_d   = '0;
        state_d = S_POLL_VALID;
      end
      S_POLL_VALID: begin
        if (m_readdata[0]) begin
          state_d = S_READ_RES;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ_RES: begin
        res_data_d = m_readdata[15:0];
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    char_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    res_valid_d  = (state_d == S_OUT);
    m_write_d    = (state_d == S_WRITE_EMB) || (state_d == S_START) || (state_d == S_DENSE);
    m_read_d     = (state_d == S_POLL_LOAD) || (state_d == S_POLL_VALID) || (state_d == S_READ_RES);
    case (state_d)
      S_WRITE_EMB, S_POLL_LOAD: m_addr_d = 3'd1;
      S_DENSE, S_READ_RES:      m_addr_d = 3'd7;
      default:                  m_addr_d = 3'd0;
    endcase
    // m_wdata_q doubles as the table's read register; same-edge writes yield old data.
    m_wdata_d = '0;
    if (state_d == S_WRITE_EMB) m_wdata_d = {8'h00, 8'(k_d), table_mem[{char_q, k_d}]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      char_q       <= '0;
      last_q       <= 1'b0;
      k_q          <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      char_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      last_q       <= last_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      char_ready_q <= char_ready_d;
      busy_q       <= busy_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
    end
  end

  assign char_ready  = char_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_addr      = m_addr_q;
  assign m_writedata = m_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rnn_sequencer.sv
// Scoreboard bench for rnn_sequencer with a small behavioural accelerator model.
`default_nettype none

module tb_rnn_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        emb_write = 1'b0;
  logic [7:0]  emb_addr = '0;
  logic [15:0] emb_data = '0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [5:0]  char_data = '0;
  logic        char_last = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        m_read, m_write;
  logic [2:0]  m_addr;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        busy, err;

  rnn_sequencer #(.CHAR_BITS(6), .EMB_BITS(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .emb_write(emb_write), .emb_addr(emb_addr),
    .emb_data(emb_data), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_last(char_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .m_read(m_read), .m_write(m_write),
    .m_addr(m_addr), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Accelerator model: load/dense complete three cycles after being kicked.
  logic        hang = 1'b0;
  logic [15:0] res_val = 16'h0000;
  logic [1:0]  ld_cnt, dn_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= '0;
      dn_cnt <= '0;
    end else begin
      if (m_write && m_addr == 3'd0) ld_cnt <= 2'd3;
      else if (ld_cnt != 0)          ld_cnt <= ld_cnt - 1'b1;
      if (m_write && m_addr == 3'd7) dn_cnt <= 2'd3;
      else if (dn_cnt != 0)          dn_cnt <= dn_cnt - 1'b1;
    end
  end

  always_comb begin
    m_readdata = 32'h0;
    if (m_read) begin
      case (m_addr)
        3'd1:    m_readdata = {31'h0, (!hang && ld_cnt == 0)};
        3'd0:    m_readdata = {31'h0, (!hang && dn_cnt == 0)};
        3'd7:    m_readdata = {16'hABCD, res_val};
        default: m_readdata = 32'h0;
      endcase
    end
  end

  typedef struct { logic [2:0] a; logic [31:0] d; } wr_t;
  wr_t         exp_wr[$];
  logic [15:0] exp_res[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_wr = -10;
  int w7 = 0;
  int r7 = 0;
  int polls = 0;
  wr_t mon_e;
  logic [15:0] mon_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic exp_w(input logic [2:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // Monitor: pops expectations whenever the DUT drives a bus write or a result handshake.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (m_read || m_write) chk("rw_excl", {31'h0, m_read && m_write}, 32'h0);
      if (m_write) begin
        if (m_addr == 3'd7) w7++;
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected actual=addr %0d data %h required=none", m_addr, m_writedata);
        end else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", {29'h0, m_addr}, {29'h0, mon_e.a});
          chk("wr_data", m_writedata, mon_e.d);
          if (m_addr == 3'd0 || (m_addr == 3'd1 && m_writedata[23:16] != 8'h00))
            chk("wr_consec", cyc - last_wr, 1);
        end
        last_wr = cyc;
      end
      if (m_read && m_addr == 3'd7) r7++;
      if (m_read && m_addr == 3'd1) polls++;
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) begin
          total++; bad++;
          $display("FAIL res_unexpected actual=%h required=none", res_data);
        end else begin
          mon_r = exp_res.pop_front();
          chk("res_data", {16'h0, res_data}, {16'h0, mon_r});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_emb(input logic [5:0] c, input logic [1:0] k, input logic [15:0] v);
    emb_write = 1'b1;
    emb_addr  = {c, k};
    emb_data  = v;
    tick();
    emb_write = 1'b0;
  endtask

  task automatic send_char(input logic [5:0] c, input logic last,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic fetch_wr, input logic [15:0] fw_val);
    int n = 0;
    while (!char_ready && n < 200) begin tick(); n++; end
    if (!char_ready) chk("ready_timeout", {31'h0, char_ready}, 32'h1);
    exp_w(3'd1, {16'h0000, e0});
    exp_w(3'd1, {16'h0001, e1});
    exp_w(3'd1, {16'h0002, e2});
    exp_w(3'd1, {16'h0003, e3});
    exp_w(3'd0, 32'h0);
    if (last && !hang) exp_w(3'd7, 32'h0);
    char_valid = 1'b1;
    char_data  = c;
    char_last  = last;
    tick();
    char_valid = 1'b0;
    char_last  = 1'b0;
    if (fetch_wr) begin
      emb_write = 1'b1;
      emb_addr  = {c, 2'd0};
      emb_data  = fw_val;
      tick();
      emb_write = 1'b0;
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (!(char_ready && !busy) && n < 300) begin tick(); n++; end
    chk("idle_reached", {31'h0, char_ready && !busy}, 32'h1);
  endtask

  task automatic wait_res;
    int n = 0;
    while (!res_valid && n < 300) begin tick(); n++; end
    chk("res_reached", {31'h0, res_valid}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w7_0, r7_0;
    tick(); tick();
    chk("rst_char_ready", {31'h0, char_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_outs", {28'h0, res_valid, m_read, m_write, err}, 32'h0);
    chk("rst_wdata", m_writedata, 32'h0);
    chk("rst_res_data", {16'h0, res_data}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_char_ready", {31'h0, char_ready}, 32'h1);
    chk("rel_busy", {31'h0, busy}, 32'h0);

    load_emb(6'd5, 2'd0, 16'h0100); load_emb(6'd5, 2'd1, 16'h0080);
    load_emb(6'd5, 2'd2, 16'hFF00); load_emb(6'd5, 2'd3, 16'h0000);
    load_emb(6'd1, 2'd0, 16'h0011); load_emb(6'd1, 2'd1, 16'h0022);
    load_emb(6'd1, 2'd2, 16'h0033); load_emb(6'd1, 2'd3, 16'h0044);
    load_emb(6'd2, 2'd0, 16'h1000); load_emb(6'd2, 2'd1, 16'h2000);
    load_emb(6'd2, 2'd2, 16'h3000); load_emb(6'd2, 2'd3, 16'h4000);
    load_emb(6'd3, 2'd0, 16'h00AA); load_emb(6'd3, 2'd1, 16'h00BB);
    load_emb(6'd3, 2'd2, 16'h00CC); load_emb(6'd3, 2'd3, 16'h00DD);

    // Single character, not last: embedding writes, start, load polls, back to idle.
    send_char(6'd5, 1'b0, 16'h0100, 16'h0080, 16'hFF00, 16'h0000, 1'b0, 16'h0);
    wait_idle();
    chk("c5_err", {31'h0, err}, 32'h0);
    chk("c5_wrq_empty", exp_wr.size(), 0);

    // Three-character sequence with result held under back-pressure.
    res_val = 16'h1234;
    w7_0 = w7; r7_0 = r7;
    send_char(6'd1, 1'b0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b0, 16'h0);
    send_char(6'd2, 1'b0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0, 16'h0);
    send_char(6'd3, 1'b1, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 1'b0, 16'h0);
    wait_res();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'h0, res_valid}, 32'h1);
      chk("hold_data", {16'h0, res_data}, 32'h1234);
      chk("hold_ready", {31'h0, char_ready}, 32'h0);
      tick();
    end
    exp_res.push_back(16'h1234);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_res_valid", {31'h0, res_valid}, 32'h0);
    chk("post_char_ready", {31'h0, char_ready}, 32'h1);
    chk("dense_writes", w7 - w7_0, 1);
    chk("result_reads", r7 - r7_0, 1);

    // Accelerator never completes: timeout after 16 polls, last flag dropped.
    hang = 1'b1;
    polls = 0;
    send_char(6'd5, 1'b1, 16'h0100, 16'h0080, 16'hFF00, 16'h0000, 1'b0, 16'h0);
    begin
      int n = 0;
      while (!err && n < 200) begin tick(); n++; end
    end
    chk("to_err", {31'h0, err}, 32'h1);
    chk("to_polls", polls, 16);
    chk("to_char_ready", {31'h0, char_ready}, 32'h1);
    chk("to_busy", {31'h0, busy}, 32'h0);
    chk("to_res_valid", {31'h0, res_valid}, 32'h0);
    hang = 1'b0;
    send_char(6'd2, 1'b0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1'b0, 16'h0);
    wait_idle();
    chk("err_sticky", {31'h0, err}, 32'h1);

    // Table write colliding with the FETCH read returns old data, new data next time.
    send_char(6'd5, 1'b0, 16'h0100, 16'h0080, 16'hFF00, 16'h0000, 1'b1, 16'h0200);
    wait_idle();
    send_char(6'd5, 1'b0, 16'h0200, 16'h0080, 16'hFF00, 16'h0000, 1'b0, 16'h0);
    wait_idle();

    // Reset in the middle of the embedding writes.
    send_char(6'd5, 1'b0, 16'h0200, 16'h0080, 16'hFF00, 16'h0000, 1'b0, 16'h0);
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {26'h0, m_read, m_write, busy, char_ready, res_valid, err}, 32'h0);
    chk("mid_rst_bus", {m_writedata[28:0], m_addr}, 32'h0);
    exp_wr.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_busy", {31'h0, busy}, 32'h0);
    chk("mid_rel_ready", {31'h0, char_ready}, 32'h1);

    // Length-one sequence after reset.
    res_val = 16'hBEEF;
    send_char(6'd5, 1'b1, 16'h0200, 16'h0080, 16'hFF00, 16'h0000, 1'b0, 16'h0);
    wait_res();
    exp_res.push_back(16'hBEEF);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("len1_done", {31'h0, res_valid}, 32'h0);

    tick(); tick();
    chk("wrq_left", exp_wr.size(), 0);
    chk("resq_left", exp_res.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rnn_sequencer.md
Name: rnn_sequencer

Overview:
- Upstream driver of the RNN accelerator. Accepts a stream of character codes and looks up each code's embedding vector in an on-chip table.
- For each character it writes the vector into the accelerator's input tensor, starts the recurrent step and polls for completion.
- After the last character of a sequence it triggers the dense layer, reads the 16-bit result and presents it on a valid/ready output.
- Acts as the bus master of the accelerator's 3-bit-address register interface.

Parameters:
- CHAR_BITS, 6, width of character code; table holds 2^CHAR_BITS entries.
- EMB_BITS, 2, log2 of embedding length; must equal accelerator embedding bits (EMB_LEN = 4).
- TIMEOUT, 4096, maximum poll cycles per wait state before error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- emb_write  in  1  table write strobe
- emb_addr  in  CHAR_BITS+EMB_BITS  {char code, element index}
- emb_data  in  16  Q8.8 embedding element
- char_valid  in  1  character available
- char_ready  out  1  character accepted when valid&&ready
- char_data  in  CHAR_BITS  character code
- char_last  in  1  last character of sequence
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  16  accelerator result, Q8.8
- m_read  out  1  accelerator read strobe
- m_write  out  1  accelerator write strobe
- m_addr  out  3  accelerator register address
- m_writedata  out  32  accelerator write data
- m_readdata  in  32  accelerator read data, combinational in the same cycle as m_read
- busy  out  1  high in any state except IDLE
- err  out  1  sticky poll timeout flag

Behaviour:
- Reset (async): state IDLE. All outputs 0 (char_ready is 0 during reset, 1 on the first IDLE cycle after release). res_data 0, err 0. Table contents are not reset.
- Table: synchronous write on emb_write, accepted in any state. Registered read, 1-cycle latency. Read and write to the same address in the same cycle returns the old data.
- char_ready = (state==IDLE). On handshake, capture char_data and char_last, then go to FETCH.
- FETCH (1 cycle): issue the table read for element 0 → WRITE_EMB.
- WRITE_EMB (EMB_LEN cycles, k = 0..3): m_write=1, m_addr=1, m_writedata = {8'h00, 8'(k), table[char][k]}. Reads are pipelined so one element is written per cycle. After k=3 → START.
- START (1 cycle): m_write=1, m_addr=0, m_writedata=0 → POLL_LOAD.
- POLL_LOAD: m_read=1, m_addr=1 every cycle. When m_readdata[0]==1: go to DENSE if last was captured, else IDLE. The first poll cycle always sees the accelerator in its start state, so no false completion is possible.
- DENSE (1 cycle): m_write=1, m_addr=7 → POLL_VALID.
- POLL_VALID: m_read=1, m_addr=0 until m_readdata[0]==1 → READ_RES.
- READ_RES (1 cycle): m_read=1, m_addr=7. Latch res_data = m_readdata[15:0]. This single read also clears the accelerator's hidden state. → OUT.
- OUT: res_valid=1 and res_data held stable until res_ready. On handshake res_valid drops next cycle → IDLE. res_ready while res_valid=0 is ignored.
- m_read and m_write are never high together. m_writedata=0 whenever m_write=0.
- Timeout: a counter resets on entry to each poll state. Reaching TIMEOUT sets err=1 → IDLE; the captured last flag is discarded. err is cleared only by reset.
- Sequences of length 1 (char_last on the first char) are legal. Back-to-back chars: IDLE lasts at least 1 cycle between characters.
- Reset mid-operation: both blocks share rst_n, so both return to idle/load. No partial result is emitted.

Test Plan:
- Table load char 5 = {0x0100, 0x0080, 0xFF00, 0x0000}; send char 5 with last=0 → 4 writes on addr 1 with data 0x00000100, 0x00010080, 0x0002FF00, 0x00030000 on consecutive cycles, then a write on addr 0, then addr-1 polls until LOAD, then char_ready=1.
- 3-char sequence with last on the 3rd char, model replying 0x1234 on addr 7 → exactly one addr-7 write and one addr-7 read; res_valid=1 with res_data=0x1234 held until res_ready.
- res_ready held low 10 cycles in OUT → res_valid and res_data stable, char_ready=0; pulse res_ready → IDLE the next cycle.
- Model never completes, TIMEOUT=16 → err=1 after 16 poll cycles, state IDLE, char_ready=1, no res_valid.
- emb_write to char 5 element 0 (0x0200) in the same cycle as FETCH reads it → old value 0x0100 written; next use of char 5 writes 0x0200.
- Assert rst_n low during WRITE_EMB → all outputs 0 immediately; after release busy=0 and char_ready=1.
